// File: rtl/uart_fifo_buffered.sv
// Buffered UART: serial core plus TX/RX circular buffers and irq status.
// Define UART_FIFO_LOOPBACK_EN to feed the core tx back into the core rx.

module uart #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic       transmit,
   input  logic [7:0] tx_byte,
   output logic       received,
   output logic [7:0] rx_byte,
   output logic       is_receiving,
   output logic       is_transmitting,
   output logic       recv_error
);
   localparam logic [15:0] BIT_TICKS  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_TICKS = 16'(CLKS_PER_BIT / 2 - 1);

   logic [9:0]  tx_shift;
   logic [3:0]  tx_bits;
   logic [15:0] tx_tick;
   logic        rx_meta;
   logic        rx_sync;
   logic        rx_armed;
   logic [3:0]  rx_bits;
   logic [15:0] rx_tick;
   logic [7:0]  rx_shift;

   assign tx = tx_shift[0];

   // Transmitter: start bit, 8 data bits LSB first, stop bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_shift        <= '1;
         tx_bits         <= '0;
         tx_tick         <= '0;
         is_transmitting <= 1'b0;
      end else if (!is_transmitting) begin
         if (transmit) begin
            tx_shift        <= {1'b1, tx_byte, 1'b0};
            tx_bits         <= 4'd10;
            tx_tick         <= BIT_TICKS;
            is_transmitting <= 1'b1;
         end
      end else if (tx_tick != 16'd0) begin
         tx_tick <= tx_tick - 16'd1;
      end else if (tx_bits == 4'd1) begin
         tx_shift        <= '1;
         tx_bits         <= '0;
         is_transmitting <= 1'b0;
      end else begin
         tx_shift <= {1'b1, tx_shift[9:1]};
         tx_bits  <= tx_bits - 4'd1;
         tx_tick  <= BIT_TICKS;
      end
   end

   // Two-flop synchroniser for the asynchronous serial input.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // Receiver: mid-bit sampling; after a bad stop bit wait for idle line.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_receiving <= 1'b0;
         rx_armed     <= 1'b0;
         rx_bits      <= '0;
         rx_tick      <= '0;
         rx_shift     <= '0;
         rx_byte      <= '0;
         received     <= 1'b0;
         recv_error   <= 1'b0;
      end else begin
         received   <= 1'b0;
         recv_error <= 1'b0;
         if (!is_receiving) begin
            if (rx_sync) begin
               rx_armed <= 1'b1;
            end else if (rx_armed) begin
               is_receiving <= 1'b1;
               rx_bits      <= '0;
               rx_tick      <= HALF_TICKS;
            end
         end else if (rx_tick != 16'd0) begin
            rx_tick <= rx_tick - 16'd1;
         end else begin
            rx_tick <= BIT_TICKS;
            if (rx_bits == 4'd0) begin
               if (rx_sync) begin
                  is_receiving <= 1'b0;
               end else begin
                  rx_bits <= 4'd1;
               end
            end else if (rx_bits != 4'd9) begin
               rx_shift <= {rx_sync, rx_shift[7:1]};
               rx_bits  <= rx_bits + 4'd1;
            end else begin
               is_receiving <= 1'b0;
               if (rx_sync) begin
                  received <= 1'b1;
                  rx_byte  <= rx_shift;
               end else begin
                  recv_error <= 1'b1;
                  rx_armed   <= 1'b0;
               end
            end
         end
      end
   end
endmodule

module uart_fifo_buffered #(
   parameter int TX_DEPTH_LOG2 = 4,
   parameter int RX_DEPTH_LOG2 = 4,
   parameter int RX_THRESHOLD  = 8,
   parameter int CLKS_PER_BIT  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rx,
   output logic                     tx,
   input  logic [7:0]               tx_byte,
   input  logic                     tx_push,
   output logic                     tx_fifo_full,
   output logic [TX_DEPTH_LOG2:0]   tx_level,
   output logic [7:0]               rx_byte,
   input  logic                     rx_pop,
   output logic                     rx_fifo_empty,
   output logic [RX_DEPTH_LOG2:0]   rx_level,
   input  logic [3:0]               irq_mask,
   input  logic [3:0]               irq_clear,
   output logic [3:0]               irq_status,
   output logic                     irq,
   output logic                     busy
);
   localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
   localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
   localparam logic [TX_DEPTH_LOG2:0] TX_FULL =
      (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);
   localparam logic [RX_DEPTH_LOG2:0] RX_FULL =
      (RX_DEPTH_LOG2 + 1)'(RX_DEPTH);
   localparam logic [RX_DEPTH_LOG2:0] RX_THR =
      (RX_DEPTH_LOG2 + 1)'(RX_THRESHOLD);
   localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_ONE =
      (TX_DEPTH_LOG2 + 1)'(1);
   localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_ONE =
      (RX_DEPTH_LOG2 + 1)'(1);
   localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE =
      (TX_DEPTH_LOG2)'(1);
   localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE =
      (RX_DEPTH_LOG2)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_KICK,
      S_WAIT_START,
      S_WAIT_END
   } tx_state_t;

   tx_state_t state;
   tx_state_t state_nxt;

   logic [7:0]               tx_mem [TX_DEPTH];
   logic [TX_DEPTH_LOG2-1:0] tx_wptr;
   logic [TX_DEPTH_LOG2-1:0] tx_rptr;
   logic [TX_DEPTH_LOG2:0]   tx_count;
   logic [TX_DEPTH_LOG2:0]   tx_count_nxt;
   logic                     tx_empty;
   logic                     tx_wr;
   logic                     tx_pop;
   logic [7:0]               hold;

   logic [7:0]               rx_mem [RX_DEPTH];
   logic [RX_DEPTH_LOG2-1:0] rx_wptr;
   logic [RX_DEPTH_LOG2-1:0] rx_rptr;
   logic [RX_DEPTH_LOG2:0]   rx_count;
   logic [RX_DEPTH_LOG2:0]   rx_count_nxt;
   logic                     rx_full;
   logic                     rx_wr;
   logic                     rx_rd;
   logic                     overrun;
   logic [3:0]               status_nxt;

   logic       core_rx;
   logic       core_tx;
   logic       core_transmit;
   logic       core_received;
   logic [7:0] core_rx_byte;
   logic       core_is_receiving;
   logic       core_is_transmitting;
   logic       core_recv_error;

`ifdef UART_FIFO_LOOPBACK_EN
   logic unused_rx;
   assign unused_rx = rx;
   assign core_rx   = core_tx;
`else
   assign core_rx = rx;
`endif

   uart #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clk            (clk),
      .rst            (~rst_n),
      .rx             (core_rx),
      .tx             (core_tx),
      .transmit       (core_transmit),
      .tx_byte        (hold),
      .received       (core_received),
      .rx_byte        (core_rx_byte),
      .is_receiving   (core_is_receiving),
      .is_transmitting(core_is_transmitting),
      .recv_error     (core_recv_error)
   );

   assign tx = core_tx;

   assign tx_empty     = tx_count == '0;
   assign tx_fifo_full = tx_count == TX_FULL;
   assign tx_pop       = state == S_LOAD;
   assign tx_wr        = tx_push && (!tx_fifo_full || tx_pop);
   assign tx_count_nxt = tx_count
                       + (tx_wr  ? TX_CNT_ONE : '0)
                       - (tx_pop ? TX_CNT_ONE : '0);
   assign tx_level     = tx_count;

   // TX storage; occupancy lives in the count so no reset is needed.
   always_ff @(posedge clk) begin
      if (tx_wr) begin
         tx_mem[tx_wptr] <= tx_byte;
      end
   end

   // TX pointers, count, and the holding register fed to the core.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_wptr  <= '0;
         tx_rptr  <= '0;
         tx_count <= '0;
         hold     <= '0;
      end else begin
         if (tx_wr) begin
            tx_wptr <= tx_wptr + TX_PTR_ONE;
         end
         if (tx_pop) begin
            tx_rptr <= tx_rptr + TX_PTR_ONE;
            hold    <= tx_mem[tx_rptr];
         end
         tx_count <= tx_count_nxt;
      end
   end

   // Launch FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Launch FSM: one transmit pulse per byte; same-cycle push starts LOAD.
   always_comb begin
      state_nxt     = state;
      core_transmit = 1'b0;
      unique case (state)
         S_IDLE: begin
            if ((!tx_empty || tx_push) && !core_is_transmitting) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            state_nxt = S_KICK;
         end
         S_KICK: begin
            core_transmit = 1'b1;
            state_nxt     = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (core_is_transmitting) begin
               state_nxt = S_WAIT_END;
            end
         end
         S_WAIT_END: begin
            if (!core_is_transmitting) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign rx_fifo_empty = rx_count == '0;
   assign rx_full       = rx_count == RX_FULL;
   assign rx_rd         = rx_pop && !rx_fifo_empty;
   assign rx_wr         = core_received && (!rx_full || rx_rd);
   assign overrun       = core_received && rx_full && !rx_rd;
   assign rx_count_nxt  = rx_count
                        + (rx_wr ? RX_CNT_ONE : '0)
                        - (rx_rd ? RX_CNT_ONE : '0);
   assign rx_level      = rx_count;
   assign rx_byte       = rx_mem[rx_rptr];

   // RX storage written from the core's received pulse.
   always_ff @(posedge clk) begin
      if (rx_wr) begin
         rx_mem[rx_wptr] <= core_rx_byte;
      end
   end

   // RX pointers and count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_wptr  <= '0;
         rx_rptr  <= '0;
         rx_count <= '0;
      end else begin
         if (rx_wr) begin
            rx_wptr <= rx_wptr + RX_PTR_ONE;
         end
         if (rx_rd) begin
            rx_rptr <= rx_rptr + RX_PTR_ONE;
         end
         rx_count <= rx_count_nxt;
      end
   end

   // Status from this cycle's events; a new set beats a clear.
   always_comb begin
      status_nxt    = '0;
      status_nxt[0] = rx_count_nxt >= RX_THR;
      status_nxt[1] = overrun || (irq_status[1] && !irq_clear[1]);
      status_nxt[2] = core_recv_error
                   || (irq_status[2] && !irq_clear[2]);
      status_nxt[3] = (tx_count_nxt == '0) && (state_nxt == S_IDLE);
   end

   // Status and interrupt registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_status <= '0;
         irq        <= 1'b0;
      end else begin
         irq_status <= status_nxt;
         irq        <= |(irq_status & irq_mask);
      end
   end

   assign busy = core_is_receiving || core_is_transmitting
              || (state != S_IDLE);
endmodule

// File: tb/tb_uart_fifo_buffered.sv
// Directed bench for uart_fifo_buffered (default build, 16 clocks/bit).

module tb_uart_fifo_buffered;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       tx;
   logic [7:0] tx_byte;
   logic       tx_push;
   logic       tx_fifo_full;
   logic [4:0] tx_level;
   logic [7:0] rx_byte;
   logic       rx_pop;
   logic       rx_fifo_empty;
   logic [4:0] rx_level;
   logic [3:0] irq_mask;
   logic [3:0] irq_clear;
   logic [3:0] irq_status;
   logic       irq;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int overlap  = 0;
   int p0;
   logic [7:0] frames[$];

   always #5 clk = ~clk;

   uart_fifo_buffered #(
      .TX_DEPTH_LOG2(4),
      .RX_DEPTH_LOG2(4),
      .RX_THRESHOLD (8),
      .CLKS_PER_BIT (16)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .tx           (tx),
      .tx_byte      (tx_byte),
      .tx_push      (tx_push),
      .tx_fifo_full (tx_fifo_full),
      .tx_level     (tx_level),
      .rx_byte      (rx_byte),
      .rx_pop       (rx_pop),
      .rx_fifo_empty(rx_fifo_empty),
      .rx_level     (rx_level),
      .irq_mask     (irq_mask),
      .irq_clear    (irq_clear),
      .irq_status   (irq_status),
      .irq          (irq),
      .busy         (busy)
   );

   // Count launch pulses and flag any issued while a frame is active.
   always @(posedge clk) begin
      if (u_dut.core_transmit) begin
         pulses <= pulses + 1;
         if (u_dut.core_is_transmitting) overlap <= overlap + 1;
      end
   end

   // Decode serial frames seen on the tx pin.
   initial begin
      forever begin
         logic [7:0] b;
         @(negedge tx);
         repeat (8) @(posedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (16) @(posedge clk);
            b[i] = tx;
         end
         repeat (16) @(posedge clk);
         frames.push_back(b);
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         repeat (16) @(negedge clk);
      end
      rx = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   task automatic wait_frames(input int n, input int budget);
      int t = 0;
      while (frames.size() < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("frames_wait", 32'(frames.size() >= n), 1);
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      while (busy && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("idle_wait", 32'(busy), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      rx        = 1'b1;
      tx_byte   = '0;
      tx_push   = 1'b0;
      rx_pop    = 1'b0;
      irq_mask  = '0;
      irq_clear = '0;
      repeat (2) @(negedge clk);
      check("rst_tx", 32'(tx), 1);
      check("rst_full", 32'(tx_fifo_full), 0);
      check("rst_empty", 32'(rx_fifo_empty), 1);
      check("rst_txlvl", 32'(tx_level), 0);
      check("rst_rxlvl", 32'(rx_level), 0);
      check("rst_status", 32'(irq_status), 0);
      check("rst_irq", 32'(irq), 0);
      check("rst_busy", 32'(busy), 0);
      rst_n    = 1'b1;
      irq_mask = 4'b1000;
      @(negedge clk);
      check("rel_status", 32'(irq_status), 'h8);
      check("rel_irq_early", 32'(irq), 0);
      @(negedge clk);
      check("rel_irq", 32'(irq), 1);
      irq_mask = '0;
      @(negedge clk);

      // single push: level, LOAD, one transmit pulse
      frames.delete();
      p0      = pulses;
      tx_byte = 8'h5A;
      tx_push = 1'b1;
      @(negedge clk);
      tx_push = 1'b0;
      check("push_lvl", 32'(tx_level), 1);
      check("push_status", 32'(irq_status), 0);
      check("push_busy", 32'(busy), 1);
      @(negedge clk);
      check("kick_lvl", 32'(tx_level), 0);
      check("kick_pulse", 32'(u_dut.core_transmit), 1);
      @(negedge clk);
      check("kick_once", 32'(u_dut.core_transmit), 0);
      wait_frames(1, 400);
      wait_idle(400);
      check("single_data", 32'(frames[0]), 'h5A);
      check("single_pulses", 32'(pulses - p0), 1);
      check("single_status", 32'(irq_status), 'h8);

      // back-to-back pushes
      frames.delete();
      p0      = pulses;
      tx_byte = 8'hA5;
      tx_push = 1'b1;
      @(negedge clk);
      tx_byte = 8'h3C;
      @(negedge clk);
      tx_push = 1'b0;
      check("b2b_lvl", 32'(tx_level), 1);
      wait_frames(2, 800);
      wait_idle(400);
      check("b2b_f0", 32'(frames[0]), 'hA5);
      check("b2b_f1", 32'(frames[1]), 'h3C);
      check("b2b_pulses", 32'(pulses - p0), 2);
      check("b2b_overlap", 32'(overlap), 0);
      check("b2b_status", 32'(irq_status), 'h8);

      // fill while a frame is in flight
      frames.delete();
      p0      = pulses;
      tx_byte = 8'h77;
      tx_push = 1'b1;
      @(negedge clk);
      tx_push = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         tx_byte = 8'(8'h10 + i);
         tx_push = 1'b1;
         @(negedge clk);
         if (i == 14) begin
            check("fill15_full", 32'(tx_fifo_full), 0);
            check("fill15_lvl", 32'(tx_level), 15);
         end
         if (i == 15) begin
            check("fill16_full", 32'(tx_fifo_full), 1);
            check("fill16_lvl", 32'(tx_level), 16);
         end
      end
      tx_push = 1'b0;
      check("fill_drop_lvl", 32'(tx_level), 16);
      check("fill_drop_full", 32'(tx_fifo_full), 1);
      wait_frames(17, 17 * 170 + 300);
      wait_idle(400);
      check("fill_count", 32'(frames.size()), 17);
      check("fill_f0", 32'(frames[0]), 'h77);
      for (int k = 0; k < 16; k++) begin
         check("fill_data", 32'(frames[k + 1]), 'h10 + k);
      end
      check("fill_pulses", 32'(pulses - p0), 17);
      check("fill_overlap", 32'(overlap), 0);

      // receive path, threshold boundary, overrun, error
      send_frame(8'h96, 1'b1);
      check("rx1_lvl", 32'(rx_level), 1);
      check("rx1_byte", 32'(rx_byte), 'h96);
      check("rx1_empty", 32'(rx_fifo_empty), 0);
      check("rx1_status", 32'(irq_status), 'h8);
      for (int i = 1; i < 7; i++) send_frame(8'(i), 1'b1);
      check("rx7_lvl", 32'(rx_level), 7);
      check("rx7_status", 32'(irq_status), 'h8);
      send_frame(8'h07, 1'b1);
      check("rx8_lvl", 32'(rx_level), 8);
      check("rx8_status", 32'(irq_status), 'h9);
      check("rx8_irq_masked", 32'(irq), 0);
      irq_mask = 4'b0001;
      @(negedge clk);
      check("rx8_irq", 32'(irq), 1);
      irq_mask = '0;
      for (int i = 8; i < 16; i++) send_frame(8'(i), 1'b1);
      check("rx16_lvl", 32'(rx_level), 16);
      send_frame(8'hEE, 1'b1);
      check("ovr_lvl", 32'(rx_level), 16);
      check("ovr_status", 32'(irq_status), 'hB);
      irq_clear = 4'b0010;
      @(negedge clk);
      irq_clear = '0;
      check("ovr_clear", 32'(irq_status), 'h9);
      fork
         send_frame(8'hDD, 1'b1);
         begin
            int n;
            n = 0;
            while (!u_dut.core_received && n < 400) begin
               @(negedge clk);
               n++;
            end
            check("ovr_seen", 32'(n < 400), 1);
            irq_clear = 4'b0010;
            @(negedge clk);
            irq_clear = '0;
            check("ovr_set_wins", 32'(irq_status[1]), 1);
         end
      join
      irq_clear = 4'b0010;
      @(negedge clk);
      irq_clear = '0;
      check("ovr_clear2", 32'(irq_status), 'h9);
      send_frame(8'h55, 1'b0);
      check("err_status", 32'(irq_status), 'hD);
      check("err_lvl", 32'(rx_level), 16);
      irq_clear = 4'b0100;
      @(negedge clk);
      irq_clear = '0;
      check("err_clear", 32'(irq_status), 'h9);

      // drain in order
      for (int k = 0; k < 16; k++) begin
         check("pop_data", 32'(rx_byte), (k == 0) ? 'h96 : k);
         rx_pop = 1'b1;
         @(negedge clk);
         rx_pop = 1'b0;
         if (k == 7) check("pop_lvl8_thr", 32'(irq_status[0]), 1);
         if (k == 8) check("pop_lvl7_thr", 32'(irq_status[0]), 0);
      end
      check("pop_empty", 32'(rx_fifo_empty), 1);
      check("pop_status", 32'(irq_status), 'h8);
      rx_pop = 1'b1;
      @(negedge clk);
      rx_pop = 1'b0;
      check("pop_on_empty", 32'(rx_level), 0);

      // reset in the middle of a frame
      tx_byte = 8'h81;
      tx_push = 1'b1;
      @(negedge clk);
      tx_byte = 8'h82;
      @(negedge clk);
      tx_push = 1'b0;
      repeat (40) @(negedge clk);
      check("mid_busy", 32'(busy), 1);
      check("mid_lvl", 32'(tx_level), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_tx", 32'(tx), 1);
      check("mid_rst_txlvl", 32'(tx_level), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_status", 32'(irq_status), 0);
      p0 = pulses;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (400) @(negedge clk);
      check("post_rst_pulses", 32'(pulses - p0), 0);
      check("post_rst_tx", 32'(tx), 1);
      check("post_rst_lvl", 32'(tx_level), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
